// File: rtl/cc_pkg.sv
// Shared types and constants for the complex accumulate-and-dump block.
package cc_pkg;

  localparam int CC_W = 32;

  typedef struct packed {
    logic signed [CC_W-1:0] re;
    logic signed [CC_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } acc_state_t;

endpackage

// File: rtl/cplx_acc_lane.sv
// One W-bit wrap-around accumulator with frame clear and sticky signed-overflow flag.
module cplx_acc_lane
  import cc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W-1:0] acc;
  logic         sticky;
  logic         add_ovf;

  assign sum     = acc + din;
  assign add_ovf = (acc[W-1] == din[W-1]) && (sum[W-1] != acc[W-1]);
  // Frame overflow as seen after this add, so the closing sample counts too.
  assign ovf     = sticky | add_ovf;

  // NOTE: sequential state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (en) begin
      if (clr) begin
        acc    <= '0;
        sticky <= 1'b0;
      end else begin
        acc    <= sum;
        sticky <= ovf;
      end
    end
  end

endmodule

// File: rtl/cplx_acc_dump.sv
// Integrates N_LEN complex samples per frame and dumps the sum through a
// valid/ready output register that back-pressures input only on frame close.
module cplx_acc_dump
  import cc_pkg::*;
#(
  parameter int N_LEN = 64,
  parameter int W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_re,
  input  logic signed [W-1:0] s_im,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [W-1:0] m_re,
  output logic signed [W-1:0] m_im,
  output logic                m_ovf
);

  localparam int                CNT_W = (N_LEN > 1) ? $clog2(N_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_LEN - 1);

  acc_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             at_last, blocked, accept, last;
  logic [W-1:0]     sum_re, sum_im;
  logic             ovf_re, ovf_im;

  assign at_last = (cnt == LAST);
  // Closing a frame needs the output register free or draining this cycle.
  assign blocked = at_last && m_valid && !m_ready;
  assign accept  = s_valid && s_ready;
  assign last    = accept && at_last;

  // NOTE: defaults first so no path leaves an output unassigned (no latch).
  always_comb begin
    state_nx = state;
    s_ready  = 1'b0;
    case (state)
      RUN: begin
        s_ready = !blocked;
        if (blocked) state_nx = WAIT;
      end
      WAIT: begin
        if (m_ready) state_nx = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (last)        cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      m_ovf   <= 1'b0;
    end else if (last) begin
      m_valid <= 1'b1;
      m_re    <= sum_re;
      m_im    <= sum_im;
      m_ovf   <= ovf_re | ovf_im;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  cplx_acc_lane #(.W(W)) u_lane_re (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .clr (last),
    .din (s_re),
    .sum (sum_re),
    .ovf (ovf_re)
  );

  cplx_acc_lane #(.W(W)) u_lane_im (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .clr (last),
    .din (s_im),
    .sum (sum_im),
    .ovf (ovf_im)
  );

endmodule

// File: tb/tb_cplx_acc_dump.sv
// Scenario bench for cplx_acc_dump (N_LEN=4, W=32) with a queue-based frame model.
module tb_cplx_acc_dump;
  import cc_pkg::*;

  localparam int N = 4;
  localparam int W = CC_W;
  localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W - 1));

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                s_valid = 1'b0;
  logic                m_ready = 1'b0;
  logic signed [W-1:0] s_re = '0;
  logic signed [W-1:0] s_im = '0;
  logic                s_ready, m_valid, m_ovf;
  logic signed [W-1:0] m_re, m_im;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    cplx_t val;
    logic  ovf;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  cplx_acc_dump #(.N_LEN(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_re    (s_re),
    .s_im    (s_im),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_re    (m_re),
    .m_im    (m_im),
    .m_ovf   (m_ovf)
  );

  // Drive just after a rising edge, return at the following falling edge.
  task automatic cyc(input logic sv, input logic signed [W-1:0] re, input logic signed [W-1:0] im,
                     input logic mr);
    @(posedge clk);
    #1;
    s_valid = sv;
    s_re    = re;
    s_im    = im;
    m_ready = mr;
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic signed [W-1:0] rnd();
    int v;
    if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 20)) - 10;
    else v = int'($urandom());
    return v;
  endfunction

  task automatic test_reset;
    do_reset();
    n_cmp++;
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
    n_cmp++;
    if (m_re !== 0 || m_im !== 0 || m_ovf !== 1'b0) begin
      n_bad++; $display("FAIL reset_m_data: got (%0d,%0d,%0b) want (0,0,0)", m_re, m_im, m_ovf);
    end
  endtask

  task automatic test_basic;
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, i, -i, 1'b1);
      n_cmp++;
      if (s_ready !== 1'b1) begin n_bad++; $display("FAIL basic_s_ready[%0d]: got %0b want 1", i, s_ready); end
    end
    cyc(1'b0, 0, 0, 1'b1);
    n_cmp++;
    if (m_valid !== 1'b1 || m_re !== 10 || m_im !== -10 || m_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_result: got v=%0b (%0d,%0d,%0b) want v=1 (10,-10,0)", m_valid, m_re, m_im, m_ovf);
    end
    cyc(1'b0, 0, 0, 1'b1);
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: got m_valid=%0b want 0", m_valid); end
  endtask

  task automatic test_back_to_back;
    int got = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(k < 8, 1, 1, 1'b1);
      if (k < 8) begin
        n_cmp++;
        if (s_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_s_ready[%0d]: got %0b want 1", k, s_ready); end
      end
      if (m_valid === 1'b1) begin
        got++;
        n_cmp++;
        if (m_re !== 4 || m_im !== 4 || m_ovf !== 1'b0) begin
          n_bad++; $display("FAIL b2b_result: got (%0d,%0d,%0b) want (4,4,0)", m_re, m_im, m_ovf);
        end
      end
    end
    n_cmp++;
    if (got != 2) begin n_bad++; $display("FAIL b2b_count: got %0d results want 2", got); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 3, -1, 1'b0);
      n_cmp++;
      if (s_ready !== 1'b1) begin n_bad++; $display("FAIL stall_open[%0d]: got s_ready=%0b want 1", i, s_ready); end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 3, -1, 1'b0);
      n_cmp++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_re !== 4 || m_im !== 8) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got rdy=%0b v=%0b (%0d,%0d) want rdy=0 v=1 (4,8)",
                 i, s_ready, m_valid, m_re, m_im);
      end
    end
    cyc(1'b1, 3, -1, 1'b1);
    n_cmp++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_drain: got rdy=%0b v=%0b want rdy=0 v=1", s_ready, m_valid);
    end
    cyc(1'b1, 3, -1, 1'b1);
    n_cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_resume: got rdy=%0b v=%0b want rdy=1 v=0", s_ready, m_valid);
    end
    cyc(1'b0, 0, 0, 1'b1);
    n_cmp++;
    if (m_valid !== 1'b1 || m_re !== 12 || m_im !== -4 || m_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_frame2: got v=%0b (%0d,%0d,%0b) want v=1 (12,-4,0)", m_valid, m_re, m_im, m_ovf);
    end
    cyc(1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_overflow;
    logic signed [W-1:0] re_t [12];
    logic signed [W-1:0] im_t [12];
    logic signed [W-1:0] want_re [3];
    logic signed [W-1:0] want_im [3];
    logic                want_ovf [3];
    re_t = '{32'h7FFFFFFF, 1, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
    im_t = '{0, 0, 0, 0,  0, 0, 0, 0,  32'h80000000, -1, 0, 0};
    want_re = '{32'h80000000, 0, 0};
    want_im = '{0, 0, 32'h7FFFFFFF};
    want_ovf = '{1'b1, 1'b0, 1'b1};
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) cyc(1'b1, re_t[f*4+i], im_t[f*4+i], 1'b1);
      cyc(1'b0, 0, 0, 1'b1);
      n_cmp++;
      if (m_valid !== 1'b1 || m_re !== want_re[f] || m_im !== want_im[f] || m_ovf !== want_ovf[f]) begin
        n_bad++;
        $display("FAIL ovf_frame[%0d]: got v=%0b (%h,%h,%0b) want v=1 (%h,%h,%0b)",
                 f, m_valid, m_re, m_im, m_ovf, want_re[f], want_im[f], want_ovf[f]);
      end
    end
    cyc(1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) cyc(1'b1, 7, 7, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b1, 9, 9, 1'b0);
    n_cmp++;
    if (m_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pending: got m_valid=%0b want 1", m_valid); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_clear: got v=%0b rdy=%0b want v=0 rdy=1", m_valid, s_ready);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 5, 5, 1'b1);
    cyc(1'b0, 0, 0, 1'b1);
    n_cmp++;
    if (m_valid !== 1'b1 || m_re !== 20 || m_im !== 20 || m_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_frame: got v=%0b (%0d,%0d,%0b) want v=1 (20,20,0)", m_valid, m_re, m_im, m_ovf);
    end
    cyc(1'b0, 0, 0, 1'b1);
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_single: got m_valid=%0b want 0", m_valid); end
  endtask

  task automatic test_random;
    int                  fin = 0, fout = 0, cycles = 0, k_in = 0;
    longint              acc_re = 0, acc_im = 0, r;
    logic                f_ovf = 1'b0;
    logic [W-1:0]        t;
    logic                hold = 1'b0, h_ovf = 1'b0;
    logic signed [W-1:0] h_re = '0, h_im = '0;
    exp_t                e;
    do_reset();
    exp_q.delete();
    while (fout < 1000 && cycles < 40000) begin
      @(posedge clk);
      #1;
      s_valid = (fin < 1000) && ($urandom_range(0, 9) < 7);
      s_re    = rnd();
      s_im    = rnd();
      m_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      cycles++;
      if (hold) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_re !== h_re || m_im !== h_im || m_ovf !== h_ovf) begin
          n_bad++;
          $display("FAIL rand_stable: got v=%0b (%0d,%0d,%0b) want v=1 (%0d,%0d,%0b)",
                   m_valid, m_re, m_im, m_ovf, h_re, h_im, h_ovf);
        end
      end
      if (m_valid === 1'b1 && m_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rand_spurious: got result (%0d,%0d) want none pending", m_re, m_im);
        end else begin
          e = exp_q.pop_front();
          if (m_re !== e.val.re || m_im !== e.val.im || m_ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL rand_result[%0d]: got (%0d,%0d,%0b) want (%0d,%0d,%0b)",
                     fout, m_re, m_im, m_ovf, e.val.re, e.val.im, e.ovf);
          end
        end
        fout++;
      end
      if (s_valid && s_ready === 1'b1) begin
        r = acc_re + longint'(s_re);
        if (r > MAXV || r < MINV) f_ovf = 1'b1;
        t = r[W-1:0];
        acc_re = longint'($signed(t));
        r = acc_im + longint'(s_im);
        if (r > MAXV || r < MINV) f_ovf = 1'b1;
        t = r[W-1:0];
        acc_im = longint'($signed(t));
        k_in++;
        if (k_in == N) begin
          e.val.re = acc_re[W-1:0];
          e.val.im = acc_im[W-1:0];
          e.ovf    = f_ovf;
          exp_q.push_back(e);
          acc_re = 0;
          acc_im = 0;
          f_ovf  = 1'b0;
          k_in   = 0;
          fin++;
        end
      end
      hold  = (m_valid === 1'b1) && !m_ready;
      h_re  = m_re;
      h_im  = m_im;
      h_ovf = m_ovf;
    end
    n_cmp++;
    if (fout != 1000) begin n_bad++; $display("FAIL rand_timeout: got %0d results want 1000", fout); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_leftover: got %0d unread want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
